// File: rtl/exe_stage_mdu.sv
// Execute stage: ALU, branch/jump target adder, N-source forwarding, multi-cycle M-extension unit, EX/MEM register.
// Optional MDU_EARLY_OUT_EN: trivial divides (divisor 0, or |divisor| > |dividend|) skip the iteration loop.
module exe_stage_mdu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FWD_SRCS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jal,
  input  logic                     jalr,
  input  logic                     branch,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     reg_write,
  input  logic                     alu_src1,
  input  logic                     alu_src2,
  input  logic [4:0]               alu_op,
  input  logic                     md_valid,
  input  logic [2:0]               md_op,
  input  logic [2:0]               data_width,
  input  logic [XLEN-1:0]          imm,
  input  logic [XLEN-1:0]          pc,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rd,
  input  logic [XLEN-1:0]          rdata1,
  input  logic [XLEN-1:0]          rdata2,
  input  logic [5*FWD_SRCS-1:0]    fwd_rd,
  input  logic [FWD_SRCS-1:0]      fwd_we,
  input  logic [XLEN*FWD_SRCS-1:0] fwd_data,
  input  logic                     mem_stall,
  output logic                     mem_read_reg,
  output logic                     mem_write_reg,
  output logic                     reg_write_reg,
  output logic [2:0]               data_width_reg,
  output logic [4:0]               rd_reg,
  output logic [XLEN-1:0]          rdata2_reg,
  output logic [XLEN-1:0]          result_reg,
  output logic                     jump_branch,
  output logic [XLEN-1:0]          target,
  output logic                     exe_stall
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN + 1);

  localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12, ALU_BGE  = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_PASS = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              negq_q, negq_d, negr_q, negr_d;
  logic              mr_q, mr_d, mw_q, mw_d, rw_q, rw_d;
  logic [2:0]        dw_q, dw_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rd2_q, rd2_d, res_q, res_d;

  logic [XLEN-1:0]   fwd_rs1, fwd_rs2, op1, op2, alu_res, tgt_sum, md_res;
  logic [XLEN-1:0]   a_abs, b_abs, quo, rem;
  logic [SHW-1:0]    shamt;
  logic              alu_branch, a_neg, b_neg;
  logic [2*XLEN-1:0] product;
  logic [XLEN+1:0]   rem_sh, diff;

  // Youngest match wins; EX/MEM beats every external source; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]               rs,
    input logic [XLEN-1:0]          rf,
    input logic                     ex_we,
    input logic [4:0]               ex_rd,
    input logic [XLEN-1:0]          ex_data,
    input logic [FWD_SRCS-1:0]      we,
    input logic [5*FWD_SRCS-1:0]    rdv,
    input logic [XLEN*FWD_SRCS-1:0] data
  );
    logic [XLEN-1:0] v;
    v = rf;
    for (int i = int'(FWD_SRCS) - 1; i >= 0; i--) begin
      if (we[i] && rdv[5*i +: 5] == rs) v = data[XLEN*i +: XLEN];
    end
    if (ex_we && ex_rd == rs) v = ex_data;
    if (rs == 5'd0) v = rf;
    return v;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(rs1, rdata1, rw_q, rd_q, res_q, fwd_we, fwd_rd, fwd_data);
    fwd_rs2 = fwd_sel(rs2, rdata2, rw_q, rd_q, res_q, fwd_we, fwd_rd, fwd_data);
  end

  // ALU and branch comparator
  always_comb begin
    op1        = alu_src1 ? fwd_rs1 : pc;
    op2        = alu_src2 ? imm : fwd_rs2;
    shamt      = op2[SHW-1:0];
    alu_res    = '0;
    alu_branch = 1'b0;
    case (alu_op)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU: alu_res = XLEN'(op1 < op2);
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = $signed(op1) >>> shamt;
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
      ALU_PASS: alu_res = op2;
      ALU_BEQ:  alu_branch = (op1 == op2);
      ALU_BNE:  alu_branch = (op1 != op2);
      ALU_BLT:  alu_branch = ($signed(op1) < $signed(op2));
      ALU_BGE:  alu_branch = ($signed(op1) >= $signed(op2));
      ALU_BLTU: alu_branch = (op1 < op2);
      ALU_BGEU: alu_branch = (op1 >= op2);
      default:  alu_res = '0;
    endcase
    if (jal || jalr) alu_res = pc + XLEN'(4);
  end

  always_comb begin
    tgt_sum     = (jalr ? fwd_rs1 : pc) + imm;
    target      = jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
    jump_branch = jal | jalr | (branch & alu_branch);
  end

  // Operand conditioning: MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MUL/MULH/DIV/REM treat rs2 as signed
  always_comb begin
    a_neg   = (md_op[2] ? ~md_op[0] : (md_op[1:0] != 2'd3)) & fwd_rs1[XLEN-1];
    b_neg   = (md_op[2] ? ~md_op[0] : (md_op[1:0] <= 2'd1)) & fwd_rs2[XLEN-1];
    a_abs   = a_neg ? -fwd_rs1 : fwd_rs1;
    b_abs   = b_neg ? -fwd_rs2 : fwd_rs2;
    product = {{XLEN{a_neg}}, fwd_rs1} * {{XLEN{b_neg}}, fwd_rs2};
  end

  // One restoring-division step: hi holds the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    rem_sh = {1'b0, hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {2'b00, dvs_q};
    quo    = negq_q ? -lo_q : lo_q;
    rem    = negr_q ? -hi_q : hi_q;
    if (!op_q[2]) md_res = (op_q[1:0] == 2'd0) ? lo_q : hi_q;
    else          md_res = op_q[1] ? rem : quo;
  end

  // MDU sequencer
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    exe_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_valid) begin
          exe_stall = 1'b1;
          if (!mem_stall) begin
            op_d   = md_op;
            negq_d = (a_neg ^ b_neg) & (fwd_rs2 != '0);
            negr_d = a_neg;
            if (!md_op[2]) begin
              {hi_d, lo_d} = product;
              state_d      = S_DONE;
            end else begin
              hi_d    = '0;
              lo_d    = a_abs;
              dvs_d   = b_abs;
              cnt_d   = CW'(XLEN);
              state_d = S_DIV;
`ifdef MDU_EARLY_OUT_EN
              if (b_abs == '0 || b_abs > a_abs) begin
                hi_d    = a_abs;
                lo_d    = (b_abs == '0) ? '1 : '0;
                state_d = S_DONE;
              end
`endif
            end
          end
        end
      end
      S_DIV: begin
        exe_stall = 1'b1;
        if (!diff[XLEN+1]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!mem_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // EX/MEM register: hold on memory stall, bubble while the MDU stalls
  always_comb begin
    mr_d  = mr_q;
    mw_d  = mw_q;
    rw_d  = rw_q;
    dw_d  = dw_q;
    rd_d  = rd_q;
    rd2_d = rd2_q;
    res_d = res_q;
    if (!mem_stall) begin
      if (exe_stall) begin
        mr_d  = 1'b0;
        mw_d  = 1'b0;
        rw_d  = 1'b0;
        dw_d  = 3'd0;
        rd_d  = 5'd0;
        rd2_d = '0;
        res_d = '0;
      end else begin
        mr_d  = mem_read;
        mw_d  = mem_write;
        rw_d  = reg_write;
        dw_d  = data_width;
        rd_d  = rd;
        rd2_d = fwd_rs2;
        res_d = (state_q == S_DONE) ? md_res : alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      dw_q    <= 3'd0;
      rd_q    <= 5'd0;
      rd2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      rw_q    <= rw_d;
      dw_q    <= dw_d;
      rd_q    <= rd_d;
      rd2_q   <= rd2_d;
      res_q   <= res_d;
    end
  end

  assign mem_read_reg   = mr_q;
  assign mem_write_reg  = mw_q;
  assign reg_write_reg  = rw_q;
  assign data_width_reg = dw_q;
  assign rd_reg         = rd_q;
  assign rdata2_reg     = rd2_q;
  assign result_reg     = res_q;
endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed testbench for exe_stage_mdu (XLEN=32, FWD_SRCS=3).
module tb_exe_stage_mdu;
`ifdef MDU_EARLY_OUT_EN
  localparam int EO_STALL = 1;
`else
  localparam int EO_STALL = 33;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, jal, jalr, branch, mem_read, mem_write, reg_write, alu_src1, alu_src2;
  logic [4:0]  alu_op, rs1, rs2, rd;
  logic        md_valid, mem_stall;
  logic [2:0]  md_op, data_width;
  logic [31:0] imm, pc, rdata1, rdata2;
  logic [14:0] fwd_rd;
  logic [2:0]  fwd_we;
  logic [95:0] fwd_data;
  logic        mem_read_reg, mem_write_reg, reg_write_reg, jump_branch, exe_stall;
  logic [2:0]  data_width_reg;
  logic [4:0]  rd_reg;
  logic [31:0] rdata2_reg, result_reg, target;

  int checks = 0;
  int errors = 0;

  exe_stage_mdu #(.XLEN(32), .FWD_SRCS(3)) dut (
    .clk(clk), .rst(rst), .jal(jal), .jalr(jalr), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .md_valid(md_valid), .md_op(md_op), .data_width(data_width),
    .imm(imm), .pc(pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rdata1(rdata1), .rdata2(rdata2),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_data(fwd_data), .mem_stall(mem_stall),
    .mem_read_reg(mem_read_reg), .mem_write_reg(mem_write_reg), .reg_write_reg(reg_write_reg),
    .data_width_reg(data_width_reg), .rd_reg(rd_reg), .rdata2_reg(rdata2_reg),
    .result_reg(result_reg), .jump_branch(jump_branch), .target(target), .exe_stall(exe_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jal = 0; jalr = 0; branch = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    alu_src1 = 0; alu_src2 = 0; alu_op = 5'd0; md_valid = 0; md_op = 3'd0;
    data_width = 3'd0; imm = 0; pc = 0; rs1 = 0; rs2 = 0; rd = 0;
    rdata1 = 0; rdata2 = 0; fwd_rd = 0; fwd_we = 0; fwd_data = 0; mem_stall = 0;
  endtask

  // Issues one M-op and reports stall length, loaded result and whether EX/MEM stayed bubbled.
  task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic [31:0] res, output logic rw, output logic bub);
    clear_inputs();
    md_valid = 1; md_op = op; rs1 = 5'd1; rs2 = 5'd2; rdata1 = a; rdata2 = b;
    rd = 5'd3; reg_write = 1;
    #1;
    n = 0; bub = 1;
    while (exe_stall && n < 100) begin
      step();
      n++;
      if (reg_write_reg) bub = 0;
    end
    step();
    res = result_reg; rw = reg_write_reg;
    clear_inputs();
    step();
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    step(); step();
    rst = 0;
    #1;
    checks++; if (result_reg !== 32'h0 || reg_write_reg !== 1'b0 || rd_reg !== 5'd0 || rdata2_reg !== 32'h0) begin
      errors++; $display("FAIL reset_regs: result=%h rw=%b rd=%0d rdata2=%h required all 0", result_reg, reg_write_reg, rd_reg, rdata2_reg); end
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", exe_stall); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    alu_op = 5'd0; alu_src1 = 1; alu_src2 = 1; imm = 0; rs1 = 5'd5; rdata1 = 32'h111;
    fwd_we = 3'b111; fwd_rd = {5'd5, 5'd5, 5'd5}; fwd_data = {32'hC, 32'hB, 32'hA};
    rd = 5'd9; reg_write = 1;
    step();
    checks++; if (result_reg !== 32'hA) begin errors++; $display("FAIL fwd_slot0: got %h required 0000000a", result_reg); end
    fwd_we = 3'b110;
    step();
    checks++; if (result_reg !== 32'hB) begin errors++; $display("FAIL fwd_slot1: got %h required 0000000b", result_reg); end
    fwd_we = 3'b111; rd = 5'd5;
    step();
    checks++; if (rd_reg !== 5'd5 || reg_write_reg !== 1'b1) begin
      errors++; $display("FAIL exmem_load: rd=%0d rw=%b required 5/1", rd_reg, reg_write_reg); end
    fwd_data = {32'hC, 32'hB, 32'hD};
    step();
    checks++; if (result_reg !== 32'hA) begin errors++; $display("FAIL fwd_exmem_prio: got %h required 0000000a", result_reg); end
    rs1 = 5'd0; fwd_rd = 15'd0; rd = 5'd9;
    step();
    checks++; if (result_reg !== 32'h111) begin errors++; $display("FAIL fwd_x0: got %h required 00000111", result_reg); end
    rs2 = 5'd7; rdata2 = 32'h222; fwd_rd = {5'd7, 5'd0, 5'd0}; fwd_we = 3'b100;
    step();
    checks++; if (rdata2_reg !== 32'hC) begin errors++; $display("FAIL fwd_rs2: got %h required 0000000c", rdata2_reg); end
    clear_inputs();
    step();
  endtask

  task automatic test_alu_branch();
    clear_inputs();
    jal = 1; pc = 32'h100; imm = 32'h20; rd = 5'd1; reg_write = 1;
    #1;
    checks++; if (target !== 32'h120 || jump_branch !== 1'b1) begin
      errors++; $display("FAIL jal: target=%h jb=%b required 00000120/1", target, jump_branch); end
    step();
    checks++; if (result_reg !== 32'h104) begin errors++; $display("FAIL jal_link: got %h required 00000104", result_reg); end
    jal = 0; jalr = 1; rs1 = 5'd3; rdata1 = 32'h1001; imm = 32'h4;
    #1;
    checks++; if (target !== 32'h1004 || jump_branch !== 1'b1) begin
      errors++; $display("FAIL jalr: target=%h jb=%b required 00001004/1", target, jump_branch); end
    jalr = 0; branch = 1; alu_op = 5'd10; alu_src1 = 1; alu_src2 = 0; rs2 = 5'd4;
    rdata1 = 32'h55; rdata2 = 32'h55; pc = 32'h200; imm = 32'h10;
    #1;
    checks++; if (target !== 32'h210 || jump_branch !== 1'b1) begin
      errors++; $display("FAIL beq_taken: target=%h jb=%b required 00000210/1", target, jump_branch); end
    rdata2 = 32'h56;
    #1;
    checks++; if (jump_branch !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b required 0", jump_branch); end
    branch = 0; alu_op = 5'd1; rdata1 = 32'd10; rdata2 = 32'd3;
    step();
    checks++; if (result_reg !== 32'd7) begin errors++; $display("FAIL alu_sub: got %h required 00000007", result_reg); end
    alu_op = 5'd7; alu_src2 = 1; rdata1 = 32'h80000000; imm = 32'd4;
    step();
    checks++; if (result_reg !== 32'hF8000000) begin errors++; $display("FAIL alu_sra: got %h required f8000000", result_reg); end
    clear_inputs();
    step();
  endtask

  task automatic test_mdu_ops();
    logic [2:0]  ops [14];
    logic [31:0] va  [14];
    logic [31:0] vb  [14];
    logic [31:0] ve  [14];
    int          vn  [14];
    int          n;
    logic [31:0] res;
    logic        rw, bub;
    ops = '{3'd5, 3'd7, 3'd1, 3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    va  = '{32'd100, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
            32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd3, 32'd3};
    vb  = '{32'd7, 32'd7, 32'h80000000, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'd0,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'd10, 32'd10};
    ve  = '{32'd14, 32'd2, 32'h40000000, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'd3};
    vn  = '{33, 33, 1, 1, 1, 1, 33, 33, EO_STALL, EO_STALL, 33, 33, EO_STALL, EO_STALL};
    for (int i = 0; i < 14; i++) begin
      issue_md(ops[i], va[i], vb[i], n, res, rw, bub);
      checks++; if (n != vn[i]) begin errors++; $display("FAIL md%0d_stall: got %0d cycles required %0d", i, n, vn[i]); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL md%0d_result: got %h required %h", i, res, ve[i]); end
      checks++; if (rw !== 1'b1) begin errors++; $display("FAIL md%0d_rw: got %b required 1", i, rw); end
      checks++; if (bub !== 1'b1) begin errors++; $display("FAIL md%0d_bubble: reg_write_reg seen high during stall", i); end
    end
  endtask

  task automatic test_fwd_into_mdu();
    int n;
    clear_inputs();
    md_valid = 1; md_op = 3'd5; rs1 = 5'd5; rs2 = 5'd6; rdata1 = 32'd0; rdata2 = 32'd7;
    fwd_we = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd5}; fwd_data = {64'd0, 32'd100};
    rd = 5'd3; reg_write = 1;
    #1;
    step();
    fwd_data = {64'd0, 32'd999}; rdata1 = 32'd555;
    n = 0;
    while (exe_stall && n < 100) begin step(); n++; end
    step();
    checks++; if (result_reg !== 32'd14) begin errors++; $display("FAIL fwd_mdu_latched: got %0d required 14", result_reg); end
    clear_inputs();
    step();
  endtask

  task automatic test_mem_stall_done();
    clear_inputs();
    md_valid = 1; md_op = 3'd0; rs1 = 5'd1; rs2 = 5'd2; rdata1 = 32'd3; rdata2 = 32'd4;
    rd = 5'd4; reg_write = 1;
    #1;
    step();
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL done_no_stall: got %b required 0", exe_stall); end
    mem_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (reg_write_reg !== 1'b0 || result_reg !== 32'd0 || exe_stall !== 1'b0) begin
        errors++; $display("FAIL memstall_hold%0d: rw=%b result=%h stall=%b required 0/0/0", c, reg_write_reg, result_reg, exe_stall); end
    end
    mem_stall = 0;
    step();
    checks++; if (result_reg !== 32'd12 || reg_write_reg !== 1'b1 || rd_reg !== 5'd4) begin
      errors++; $display("FAIL memstall_release: result=%0d rw=%b rd=%0d required 12/1/4", result_reg, reg_write_reg, rd_reg); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_div();
    int          n;
    logic [31:0] res;
    logic        rw, bub;
    clear_inputs();
    md_valid = 1; md_op = 3'd5; rs1 = 5'd1; rs2 = 5'd2; rdata1 = 32'd100; rdata2 = 32'd7;
    rd = 5'd3; reg_write = 1;
    #1;
    repeat (5) step();
    rst = 1; clear_inputs(); rdata2 = 32'h77; rd = 5'd8; reg_write = 1;
    step();
    rst = 0;
    #1;
    checks++; if (exe_stall !== 1'b0) begin errors++; $display("FAIL rst_div_stall: got %b required 0", exe_stall); end
    checks++; if (result_reg !== 32'd0 || reg_write_reg !== 1'b0 || rd_reg !== 5'd0 || rdata2_reg !== 32'd0) begin
      errors++; $display("FAIL rst_div_regs: result=%h rw=%b rd=%0d rdata2=%h required all 0", result_reg, reg_write_reg, rd_reg, rdata2_reg); end
    clear_inputs();
    issue_md(3'd0, 32'd6, 32'd7, n, res, rw, bub);
    checks++; if (n != 1 || res !== 32'd42) begin
      errors++; $display("FAIL rst_div_after: stall=%0d result=%0d required 1/42", n, res); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu_branch();
    test_mdu_ops();
    test_fwd_into_mdu();
    test_mem_stall_done();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
